// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling, valid/ready word output with error pulses.
// Optional even-parity bit after the data bits is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int BAUD = 921600,
    parameter int CLKF = 100000000,
    parameter int DLEN = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_rxs,
    output logic            o_tvalid,
    input  logic            i_tready,
    output logic [DLEN-1:0] o_tdata,
    output logic            o_ferr,
    output logic            o_oerr,
    output logic            o_perr
);

    localparam int BAUD_LIM = CLKF / BAUD - 1;
    localparam int HALF_LIM = BAUD_LIM / 2;
    localparam int CNT_W    = (BAUD_LIM < 1) ? 1 : $clog2(BAUD_LIM + 1);
    localparam int BIT_W    = $clog2(DLEN + 1);

    localparam logic [CNT_W-1:0] CNT_BAUD = CNT_W'(BAUD_LIM);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_LIM);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DLEN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

`ifdef UART_RX_PARITY_EN
    function automatic logic par_err(input logic [DLEN-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction
`endif

    logic             rxs_p0;
    logic             rxs_p1;
    logic             rxs_p2;
    logic             fall_edge;
    logic             baud_tick;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_cnt_nxt;
    logic [DLEN-1:0]  shreg;
    logic [DLEN-1:0]  shreg_nxt;
    logic             commit;
    logic             ferr_set;
    logic             overrun;
`ifdef UART_RX_PARITY_EN
    logic             par_bit;
    logic             par_bit_nxt;
    logic             perr_set;
`endif

    // Stage p0/p1: metastability synchronizer, p2: history for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxs_p0 <= 1'b1;
            rxs_p1 <= 1'b1;
            rxs_p2 <= 1'b1;
        end else begin
            rxs_p0 <= i_rxs;
            rxs_p1 <= rxs_p0;
            rxs_p2 <= rxs_p1;
        end
    end

    assign fall_edge = rxs_p2 && !rxs_p1;
    assign baud_tick = (cnt == CNT_BAUD);

    // Frame sequencer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
`ifdef UART_RX_PARITY_EN
            par_bit <= par_bit_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        commit      = 1'b0;
        ferr_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_nxt = par_bit;
        perr_set    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                cnt_nxt     = '0;
                bit_cnt_nxt = '0;
                if (fall_edge) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (cnt == CNT_HALF) begin
                    // A line already back high at mid start bit was a glitch
                    state_nxt = rxs_p1 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    shreg_nxt   = {rxs_p1, shreg[DLEN-1:1]};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (baud_tick) begin
                    par_bit_nxt = rxs_p1;
                    state_nxt   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (baud_tick) begin
                    state_nxt = S_IDLE;
                    if (!rxs_p1) begin
                        ferr_set = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_err(shreg, par_bit)) begin
                        perr_set = 1'b1;
`endif
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (state_nxt != state || baud_tick) begin
            cnt_nxt = '0;
        end
    end

    assign overrun = commit && o_tvalid && !i_tready;

    // Output word holding register and one-cycle error pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_ferr   <= 1'b0;
            o_oerr   <= 1'b0;
        end else begin
            o_ferr <= ferr_set;
            o_oerr <= overrun;
            if (commit && !overrun) begin
                o_tvalid <= 1'b1;
                o_tdata  <= shreg;
            end else if (o_tvalid && i_tready) begin
                o_tvalid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_perr <= 1'b0;
        end else begin
            o_perr <= perr_set;
        end
    end
`else
    assign o_perr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit (CLKF=16 MHz, BAUD=1 MHz, DLEN=8).
module tb_uart_rx;

    localparam int BIT_T = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 155 + BIT_T;
`else
    localparam int LAT = 155;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       i_rxs = 1'b1;
    logic       i_tready = 1'b1;
    logic       o_tvalid;
    logic [7:0] o_tdata;
    logic       o_ferr;
    logic       o_oerr;
    logic       o_perr;

    uart_rx #(.BAUD(1000000), .CLKF(16000000), .DLEN(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_rxs    (i_rxs),
        .o_tvalid (o_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_ferr   (o_ferr),
        .o_oerr   (o_oerr),
        .o_perr   (o_perr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    int vld_hi, hs_cnt, ferr_hi, oerr_hi, perr_hi, rise_cyc, start_cyc;
    logic [7:0] hs_data;
    logic vld_q = 1'b0;

    always @(negedge clk) begin
        #1;
        if (o_tvalid) vld_hi++;
        if (o_tvalid && !vld_q) rise_cyc = cyc;
        if (o_tvalid && i_tready) begin
            hs_cnt++;
            hs_data = o_tdata;
        end
        if (o_ferr) ferr_hi++;
        if (o_oerr) oerr_hi++;
        if (o_perr) perr_hi++;
        vld_q = o_tvalid;
    end

    task automatic clr();
        vld_hi = 0; hs_cnt = 0; ferr_hi = 0; oerr_hi = 0; perr_hi = 0;
        rise_cyc = -1; hs_data = 8'h00;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_raw(input logic [7:0] d, input logic p, input logic stop);
        start_cyc = cyc;
        i_rxs = 1'b0; idle(BIT_T);
        for (int b = 0; b < 8; b++) begin
            i_rxs = d[b]; idle(BIT_T);
        end
        i_rxs = p; idle(BIT_T);
        i_rxs = stop; idle(BIT_T);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_raw(d, ^d, stop);
    endtask
`else
    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        i_rxs = 1'b0; idle(BIT_T);
        for (int b = 0; b < 8; b++) begin
            i_rxs = d[b]; idle(BIT_T);
        end
        i_rxs = stop; idle(BIT_T);
    endtask
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_vld;
        int         exp_ferr;
        logic [7:0] exp_tdata;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[3] = '{8'h55, 1'b0, 0, 1, 8'hFF};
        vecs[4] = '{8'h81, 1'b1, 1, 0, 8'h81};
        clr();

        idle(3);
        check("rst_tvalid", o_tvalid, 0);
        check("rst_tdata", o_tdata, 0);
        check("rst_ferr", o_ferr, 0);
        check("rst_oerr", o_oerr, 0);
        check("rst_perr", o_perr, 0);
        rstn = 1'b1;
        idle(5);

        for (int i = 0; i < 5; i++) begin
            clr();
            i_tready = 1'b1;
            send_frame(vecs[i].data, vecs[i].stop);
            if (!vecs[i].stop) idle(48);
            i_rxs = 1'b1;
            idle(40);
            check($sformatf("vec%0d_vld_cycles", i), vld_hi, vecs[i].exp_vld);
            check($sformatf("vec%0d_handshakes", i), hs_cnt, vecs[i].exp_vld);
            check($sformatf("vec%0d_tdata", i), o_tdata, vecs[i].exp_tdata);
            check($sformatf("vec%0d_ferr_cycles", i), ferr_hi, vecs[i].exp_ferr);
            check($sformatf("vec%0d_oerr_cycles", i), oerr_hi, 0);
            check($sformatf("vec%0d_perr_cycles", i), perr_hi, 0);
            if (vecs[i].stop) check($sformatf("vec%0d_latency", i), rise_cyc - start_cyc, LAT);
        end

        // Overrun: two back-to-back frames with the consumer stalled
        clr();
        i_tready = 1'b0;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        idle(40);
        check("ovr_tvalid", o_tvalid, 1);
        check("ovr_tdata", o_tdata, 8'h3C);
        check("ovr_oerr_cycles", oerr_hi, 1);
        check("ovr_hs_before", hs_cnt, 0);
        i_tready = 1'b1;
        idle(4);
        check("ovr_hs_after", hs_cnt, 1);
        check("ovr_hs_data", hs_data, 8'h3C);
        check("ovr_tvalid_after", o_tvalid, 0);

        // Commit in the same cycle as a handshake
        i_tready = 1'b0;
        send_frame(8'h12, 1'b1);
        idle(20);
        clr();
        fork
            send_frame(8'h34, 1'b1);
            begin
                idle(LAT - 1);
                i_tready = 1'b1;
                idle(1);
                i_tready = 1'b0;
            end
        join
        idle(10);
        check("same_hs_cnt", hs_cnt, 1);
        check("same_hs_data", hs_data, 8'h12);
        check("same_tvalid", o_tvalid, 1);
        check("same_tdata", o_tdata, 8'h34);
        check("same_oerr", oerr_hi, 0);
        i_tready = 1'b1;
        idle(3);
        check("same_drain_hs", hs_cnt, 2);
        check("same_drain_data", hs_data, 8'h34);
        check("same_drain_tvalid", o_tvalid, 0);

        // 4-clock low glitch on an idle line
        clr();
        i_rxs = 1'b0; idle(4);
        i_rxs = 1'b1; idle(40);
        check("glitch_vld", vld_hi, 0);
        check("glitch_flags", ferr_hi + oerr_hi + perr_hi, 0);
        send_frame(8'h5A, 1'b1);
        idle(20);
        check("glitch_next_hs", hs_cnt, 1);
        check("glitch_next_data", hs_data, 8'h5A);

        // Reset during the fourth data bit with a word still pending
        i_tready = 1'b0;
        send_frame(8'h66, 1'b1);
        idle(20);
        check("pre_rst_tvalid", o_tvalid, 1);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                idle(BIT_T * 4 + 8);
                rstn = 1'b0;
                #1;
                check("midrst_tvalid", o_tvalid, 0);
                check("midrst_tdata", o_tdata, 0);
                check("midrst_flags", {o_ferr, o_oerr, o_perr}, 0);
                idle(3);
                rstn = 1'b1;
            end
        join
        clr();
        i_tready = 1'b1;
        idle(40);
        check("postrst_vld", vld_hi, 0);
        check("postrst_ferr", ferr_hi, 0);
        send_frame(8'h81, 1'b1);
        idle(20);
        check("postrst_hs", hs_cnt, 1);
        check("postrst_data", hs_data, 8'h81);

`ifdef UART_RX_PARITY_EN
        clr();
        send_raw(8'h07, 1'b0, 1'b1);
        idle(40);
        check("par_bad_perr", perr_hi, 1);
        check("par_bad_vld", vld_hi, 0);
        check("par_bad_ferr", ferr_hi, 0);
        clr();
        send_raw(8'h07, 1'b1, 1'b1);
        idle(40);
        check("par_ok_hs", hs_cnt, 1);
        check("par_ok_data", hs_data, 8'h07);
        check("par_ok_perr", perr_hi, 0);
        clr();
        send_raw(8'h07, 1'b0, 1'b0);
        idle(48);
        i_rxs = 1'b1;
        idle(40);
        check("par_ferr_prec_ferr", ferr_hi, 1);
        check("par_ferr_prec_perr", perr_hi, 0);
        check("par_ferr_prec_vld", vld_hi, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD, default 921600, line bit rate in bits/s.
REQ-002 SHALL have parameter CLKF, default 100000000, clk frequency in Hz.
REQ-003 SHALL have parameter DLEN, default 8, data bits per frame.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port i_rxs  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port o_tvalid  output  1  received word valid.
REQ-008 SHALL have port i_tready  input  1  consumer ready.
REQ-009 SHALL have port o_tdata  output  DLEN  received word, LSB = first data bit.
REQ-010 SHALL have port o_ferr  output  1  framing-error pulse.
REQ-011 SHALL have port o_oerr  output  1  overrun-error pulse.
REQ-012 SHALL have port o_perr  output  1  parity-error pulse; constant 0 unless UART_RX_PARITY_EN is defined.

Function
REQ-013 SHALL pass i_rxs through a 2-flop synchronizer (reset value 1) plus 1 history flop; all decisions use synchronized values.
REQ-014 SHALL define BaudLimit = CLKF/BAUD - 1 (integer divide) and HalfLimit = BaudLimit/2; the baud counter is sized for BaudLimit and clears on every state change.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY (only with UART_RX_PARITY_EN), STOP.
REQ-016 IDLE: SHALL go to START only on a synchronized high-to-low edge; a line held low SHALL NOT retrigger.
REQ-017 START: at count HalfLimit, SHALL sample the line; if low, go to DATA; if high (glitch), return to IDLE with no flags and no output.
REQ-018 DATA: SHALL sample every BaudLimit+1 cycles, starting BaudLimit+1 cycles after the start-bit mid-sample, and shift into a DLEN-bit register LSB first; after DLEN samples, go to STOP (or to PARITY).
REQ-019 STOP: one bit time after the last sample, SHALL sample the line and then go to IDLE.
REQ-020 On stop sample = 1, SHALL commit the word: load o_tdata and set o_tvalid the next cycle (total latency = stop mid-sample + 1 clk).
REQ-021 On stop sample = 0, SHALL discard the word, pulse o_ferr for exactly 1 cycle and leave o_tvalid/o_tdata unchanged.
REQ-022 o_tvalid SHALL stay high and o_tdata stable until a cycle with o_tvalid && i_tready, after which o_tvalid clears unless a commit happens in the same cycle.
REQ-023 A commit while o_tvalid=1 and i_tready=0 SHALL keep the old word, drop the new one and pulse o_oerr for 1 cycle.
REQ-024 A commit in the same cycle as a handshake SHALL load the new word, keep o_tvalid=1 and not flag an overrun.
REQ-025 Receiving SHALL continue regardless of o_tvalid; there is no backpressure on the line.
REQ-026 An illegal state encoding SHALL recover to IDLE on the next cycle.

Reset
REQ-027 rstn low SHALL immediately force: state IDLE, counters 0, synchronizer/history 1, o_tvalid 0, o_tdata 0, and o_ferr/o_oerr/o_perr 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no output; after release, reception resumes at the next falling edge.

Configuration
REQ-029 With macro UART_RX_PARITY_EN defined, SHALL receive one even-parity bit after the data bits (PARITY state, sampled one bit time after the last data bit). On mismatch at a valid stop bit, SHALL pulse o_perr for 1 cycle and discard the word; a framing error takes precedence.
REQ-030 Without UART_RX_PARITY_EN, SHALL have no PARITY state, frames are start+DLEN+stop, and o_perr is tied to 0.

Verification (CLKF=16000000, BAUD=1000000, DLEN=8: BaudLimit=15, HalfLimit=7)
REQ-031 Send frame 0xA5 with i_tready=1 -> o_tvalid is high for 1 cycle with o_tdata=0xA5, and no error flags.
REQ-032 Send 0x3C then 0xC3 back-to-back with i_tready=0 -> o_tdata holds 0x3C, o_oerr pulses once at the second commit; raising i_tready then gives one handshake and o_tvalid=0.
REQ-033 Send 0x55 with stop bit driven 0 -> o_ferr pulses 1 cycle, o_tvalid stays 0, and the line held low afterwards causes no new frame.
REQ-034 Drive a 4-clk low glitch on the idle line -> no output, no flags, state back to IDLE.
REQ-035 Pull rstn low during the 4th data bit of 0xFF -> outputs reset at once; a following frame 0x81 is received correctly.
REQ-036 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> o_perr pulses once and no o_tvalid; send 0x07 with parity bit 1 -> word delivered.
